// File: rtl/inst_encoder_fifo_if.sv
// Handshake bundle for inst_encoder_fifo: field input side, encoded-word output
// side, plus flush and status. The slave modport is the encoder's view.
interface inst_encoder_fifo_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [3:0]       in_ra;
  logic [3:0]       in_rb;
  logic [31:0]      in_imm;
  logic [38:0]      inst;
  logic             inst_valid;
  logic             inst_ready;
  logic [LVL_W-1:0] level;
  logic [CNT_W-1:0] issue_count;

  modport slave (
    input  flush, in_valid, in_op, in_ra, in_rb, in_imm, inst_ready,
    output in_ready, inst, inst_valid, level, issue_count
  );

  modport master (
    output flush, in_valid, in_op, in_ra, in_rb, in_imm, inst_ready,
    input  in_ready, inst, inst_valid, level, issue_count
  );
endinterface

// File: rtl/inst_encoder_fifo.sv
// Packs instruction fields into the 39-bit decoder word and buffers them in a
// DEPTH-entry FIFO; counts words handed to the core.
module inst_encoder_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  inst_encoder_fifo_if.slave    bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [38:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic [CNT_W-1:0] r_issue_count;

  logic [38:0]      w_enc;
  logic             w_in_ready;
  logic             w_inst_valid;
  logic             w_push;
  logic             w_pop;

  // Opcode selects which fields are carried; unused fields are forced to zero.
  always_comb begin
    w_enc = '0;
    case (bus.in_op)
      3'b000:  w_enc = '0;
      3'b001:  w_enc = {bus.in_op, bus.in_ra, bus.in_imm};
      3'b010:  w_enc = {bus.in_op, bus.in_rb, bus.in_imm};
      default: w_enc = {bus.in_op, bus.in_ra, bus.in_rb, 28'b0};
    endcase
  end

  assign w_in_ready   = (r_level != LVL_W'(DEPTH));
  assign w_inst_valid = (r_level != '0);
  assign w_push       = bus.in_valid && w_in_ready;
  assign w_pop        = w_inst_valid && bus.inst_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_level       <= '0;
      r_issue_count <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr      <= r_rd_ptr + 1'b1;
        r_issue_count <= r_issue_count + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only visible once level covers it.
  always_ff @(posedge clk) begin
    if (rst_n && !bus.flush && w_push) begin
      r_mem[r_wr_ptr] <= w_enc;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.inst_valid  = w_inst_valid;
  assign bus.inst        = w_inst_valid ? r_mem[r_rd_ptr] : '0;
  assign bus.level       = r_level;
  assign bus.issue_count = r_issue_count;
endmodule

// File: tb/tb_inst_encoder_fifo.sv
// Directed self-checking bench for inst_encoder_fifo.
module tb_inst_encoder_fifo;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  inst_encoder_fifo_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  inst_encoder_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [3:0] ra,
                            input logic [3:0] rb, input logic [31:0] imm);
    bus.in_op  = op;
    bus.in_ra  = ra;
    bus.in_rb  = rb;
    bus.in_imm = imm;
  endtask

  task automatic push_one(input logic [2:0] op, input logic [3:0] ra,
                          input logic [3:0] rb, input logic [31:0] imm);
    set_fields(op, ra, rb, imm);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic pop_one();
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
  endtask

  logic [38:0]      q[$];
  logic [38:0]      w;
  logic [CNT_W-1:0] exp_cnt;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.inst_ready = 1'b0;
    set_fields(3'd0, 4'd0, 4'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    check("rst_level", 64'(bus.level), 0);
    check("rst_valid", 64'(bus.inst_valid), 0);
    check("rst_in_ready", 64'(bus.in_ready), 1);
    check("rst_inst", 64'(bus.inst), 0);
    check("rst_count", 64'(bus.issue_count), 0);

    // Single load-A word, consumer always ready
    bus.inst_ready = 1'b1;
    push_one(3'b001, 4'h3, 4'h0, 32'hDEADBEEF);
    check("ldA_inst", 64'(bus.inst), 64'h13DEADBEEF);
    check("ldA_valid", 64'(bus.inst_valid), 1);
    check("ldA_level", 64'(bus.level), 1);
    tick();
    bus.inst_ready = 1'b0;
    check("ldA_count", 64'(bus.issue_count), 1);
    check("ldA_level0", 64'(bus.level), 0);
    check("ldA_valid0", 64'(bus.inst_valid), 0);

    push_one(3'b010, 4'hF, 4'hA, 32'h0000_0055);
    check("ldB_inst", 64'(bus.inst), 64'h2A00000055);
    pop_one();
    push_one(3'b101, 4'h2, 4'h7, 32'hFFFF_FFFF);
    check("alu5_inst", 64'(bus.inst), 64'h5270000000);
    pop_one();
    push_one(3'b111, 4'h1, 4'h2, 32'hFFFF_FFFF);
    check("alu7_inst", 64'(bus.inst), 64'h7120000000);
    pop_one();
    push_one(3'b000, 4'hF, 4'hF, 32'hFFFF_FFFF);
    check("rfrst_inst", 64'(bus.inst), 0);
    check("rfrst_valid", 64'(bus.inst_valid), 1);
    pop_one();
    check("enc_count", 64'(bus.issue_count), 5);

    // Fill to DEPTH with the consumer stalled
    for (int i = 0; i < 4; i++) push_one(3'b001, 4'(i), 4'h0, 32'h100 + 32'(i));
    check("full_level", 64'(bus.level), 4);
    check("full_in_ready", 64'(bus.in_ready), 0);
    check("full_head", 64'(bus.inst), {25'd0, 3'b001, 4'h0, 32'h100});
    push_one(3'b001, 4'hF, 4'h0, 32'hBAD);
    check("full_reject_level", 64'(bus.level), 4);
    check("full_stable_head", 64'(bus.inst), {25'd0, 3'b001, 4'h0, 32'h100});
    // Pop while full with in_valid high: no pass-through
    bus.in_valid = 1'b1;
    set_fields(3'b001, 4'hE, 4'h0, 32'hBAD);
    bus.inst_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("full_pop_level", 64'(bus.level), 3);
    for (int i = 1; i < 4; i++) begin
      check("drain_order", 64'(bus.inst), {25'd0, 3'b001, 4'(i), 32'h100 + 32'(i)});
      tick();
    end
    bus.inst_ready = 1'b0;
    check("drain_level", 64'(bus.level), 0);
    check("drain_count", 64'(bus.issue_count), 9);

    // Level 2 then simultaneous push/pop across pointer wrap
    exp_cnt = 16'd9;
    for (int i = 0; i < 2; i++) begin
      w = {3'b001, 4'(8 + i), 32'hA000 + 32'(i)};
      q.push_back(w);
      push_one(3'b001, 4'(8 + i), 4'h0, 32'hA000 + 32'(i));
    end
    for (int i = 2; i < 7; i++) begin
      check("pp_head", 64'(bus.inst), 64'(q[0]));
      w = {3'b001, 4'(8 + i), 32'hA000 + 32'(i)};
      q.push_back(w);
      void'(q.pop_front());
      exp_cnt++;
      set_fields(3'b001, 4'(8 + i), 4'h0, 32'hA000 + 32'(i));
      bus.in_valid = 1'b1;
      bus.inst_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.inst_ready = 1'b0;
      check("pp_level", 64'(bus.level), 2);
    end
    while (q.size() > 0) begin
      check("pp_drain", 64'(bus.inst), 64'(q[0]));
      void'(q.pop_front());
      exp_cnt++;
      pop_one();
    end
    check("pp_count", 64'(bus.issue_count), 64'(exp_cnt));

    // Push and pop requested at empty: push only
    set_fields(3'b011, 4'h4, 4'h5, 32'h0);
    bus.in_valid = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.inst_ready = 1'b0;
    check("empty_pp_level", 64'(bus.level), 1);
    check("empty_pp_count", 64'(bus.issue_count), 64'(exp_cnt));
    check("empty_pp_inst", 64'(bus.inst), 64'h3450000000);

    // Flush at level 3 overrides push and pop
    push_one(3'b001, 4'h1, 4'h0, 32'h1);
    push_one(3'b001, 4'h2, 4'h0, 32'h2);
    check("pre_flush_level", 64'(bus.level), 3);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.inst_ready = 1'b0;
    check("flush_level", 64'(bus.level), 0);
    check("flush_valid", 64'(bus.inst_valid), 0);
    check("flush_inst", 64'(bus.inst), 0);
    check("flush_count", 64'(bus.issue_count), 64'(exp_cnt));
    push_one(3'b010, 4'h0, 4'h6, 32'h1234_5678);
    check("post_flush_inst", 64'(bus.inst), 64'h2612345678);

    // Stream push+pop at level 1 until the counter reaches all-ones
    bus.in_valid = 1'b1;
    bus.inst_ready = 1'b1;
    set_fields(3'b110, 4'h1, 4'h1, 32'h0);
    repeat (int'(16'hFFFF - exp_cnt)) tick();
    bus.in_valid = 1'b0;
    bus.inst_ready = 1'b0;
    check("cnt_max", 64'(bus.issue_count), 64'hFFFF);
    check("cnt_max_level", 64'(bus.level), 1);
    pop_one();
    check("cnt_wrap", 64'(bus.issue_count), 0);
    check("cnt_wrap_level", 64'(bus.level), 0);

    // Reset mid-stream at level 3
    for (int i = 0; i < 3; i++) push_one(3'b001, 4'(i), 4'h0, 32'(i));
    pop_one();
    check("pre_rst_count", 64'(bus.issue_count), 1);
    push_one(3'b001, 4'h7, 4'h0, 32'h7);
    check("pre_rst_level", 64'(bus.level), 3);
    rst_n = 1'b0;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.inst_ready = 1'b0;
    check("rst2_level", 64'(bus.level), 0);
    check("rst2_count", 64'(bus.issue_count), 0);
    check("rst2_valid", 64'(bus.inst_valid), 0);
    check("rst2_in_ready", 64'(bus.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/inst_encoder_fifo.md
Name: inst_encoder_fifo

Overview:
- Producer side of the 39-bit instruction word consumed by the core's instruction decoder.
- Accepts instruction fields (opcode, register indices, immediate) from the host or loader over a valid/ready handshake.
- Packs the fields into the 39-bit format and buffers them in a small FIFO.
- Presents one encoded word per cycle to the core under a second valid/ready handshake, and counts issued instructions.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous FIFO clear.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- in_op  input  3  opcode.
- in_ra  input  4  register A index.
- in_rb  input  4  register B index.
- in_imm  input  32  immediate for load ops.
- inst  output  39  encoded word at FIFO head.
- inst_valid  output  1  inst is valid.
- inst_ready  input  1  core consumes inst this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- issue_count  output  CNT_W  instructions handed to the core.

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is synchronous and active-low.
- Reset (rst_n=0 at a clock edge):
  - Pointers and level go to 0; issue_count goes to 0.
  - inst_valid=0, in_ready=1 on the following cycle.
  - inst reads as 39'b0 while the FIFO is empty.
  - Reset mid-stream discards all entries; no partial word is ever issued.
- Encoding (combinational, applied at push; bits [38:36]=in_op always):
  - op 000 (register-file reset): inst = {3'b000, 36'b0}; ra, rb and imm are ignored.
  - op 001 (load A): inst = {3'b001, in_ra, in_imm}.
  - op 010 (load B): inst = {3'b010, in_rb, in_imm}. The B index goes in [35:32].
  - op 011..111 (ALU): inst = {in_op, in_ra, in_rb, 28'b0}; imm is ignored.
- Push: occurs when in_valid && in_ready at an edge. The encoded word is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when inst_valid && inst_ready at an edge. rd_ptr increments modulo DEPTH, and issue_count increments, wrapping at 2^CNT_W-1 -> 0.
- Outputs:
  - in_ready = (level != DEPTH), combinational from registered level. No pass-through when full, even if a pop occurs in the same cycle.
  - inst_valid = (level != 0). inst = mem[rd_ptr] when valid, else 0.
- Latency: a bundle accepted at edge N is visible on inst/inst_valid in the cycle after edge N (1 cycle). No bypass path.
- Simultaneous push and pop (0 < level < DEPTH): both occur and level is unchanged.
- Push and pop with level==0: push only; the entry pops no earlier than the next cycle.
- Stable output: inst and inst_valid stay stable while inst_valid && !inst_ready.
- Flush:
  - flush=1 at an edge sets level=0 and rd_ptr=wr_ptr=0.
  - Flush overrides a push and a pop in that cycle. The word is dropped and issue_count does not increment.
  - issue_count is kept across flush.
- Priority: rst_n over flush over push/pop.
- No state machine beyond the FIFO pointers. level is exact at all times (0..DEPTH).

Test Plan:
- Reset then single push op=001, ra=4'h3, imm=32'hDEADBEEF, inst_ready=1 -> cycle after accept inst=39'h13DEADBEEF, inst_valid=1; it pops, issue_count=1, level returns to 0.
- Encode op=010, rb=4'hA, imm=32'h0000_0055 -> inst=39'h2A00000055. Separately, op=101, ra=4'h2, rb=4'h7 -> inst=39'h5270000000. op=000 with nonzero fields -> inst=0.
- inst_ready=0, push 4 bundles -> level=4, in_ready=0, and a 5th in_valid is not accepted. Then inst_ready=1 -> words drain in order over 4 cycles and issue_count increases by 4.
- level=2, push and pop in the same cycle -> level stays 2, FIFO order is preserved, and wrap of wr_ptr/rd_ptr past DEPTH-1 is correct.
- level=3, flush asserted together with in_valid and inst_ready -> next cycle level=0, inst_valid=0, and issue_count is unchanged.
- issue_count preset to 16'hFFFF via pops, then one more pop -> issue_count=0. rst_n=0 with level=3 -> level=0, issue_count=0, inst_valid=0.
